// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH divided clocks from clock, each with a one-cycle tick on every toggle and a glitch-free runtime divisor.
// Latency: all outputs registered; a divisor write shows on pending one edge later and applies at the channel's next terminal count.
// Backpressure: none; the last write before application wins. Optional CLKDIV_SYNC_EN makes sync realign all channel phases.
module clk_div_bank #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 51,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              load_valid,
    input  logic [CH_W-1:0]   load_ch,
    input  logic [DIV_W-1:0]  load_div,
    input  logic              sync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    logic [DIV_W-1:0]  cnt   [NUM_CH];
    logic [DIV_W-1:0]  div_q [NUM_CH];
    logic [DIV_W-1:0]  div_p [NUM_CH];
    logic [NUM_CH-1:0] stop, term, sel, apply;
    logic              sync_hit;

`ifdef CLKDIV_SYNC_EN
    assign sync_hit = sync;
`else
    logic unused_sync;
    assign unused_sync = sync;
    assign sync_hit    = 1'b0;
`endif

    // A stopped channel (disabled, zero divisor or realigned) takes a queued divisor at once.
    always_comb begin
        stop  = '0;
        term  = '0;
        sel   = '0;
        apply = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            stop[i]  = sync_hit || !en[i] || (div_q[i] == '0);
            term[i]  = !stop[i] && (cnt[i] == div_q[i] - DIV_W'(1));
            sel[i]   = load_valid && (32'(load_ch) == i);
            apply[i] = pending[i] && (stop[i] || term[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i]   <= '0;
                div_q[i] <= DIV_W'(DEFAULT_DIV);
                div_p[i] <= DIV_W'(DEFAULT_DIV);
            end
            clk_out <= '0;
            tick    <= '0;
            pending <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (stop[i]) begin
                    cnt[i]     <= '0;
                    clk_out[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                end else if (term[i]) begin
                    cnt[i]     <= '0;
                    clk_out[i] <= ~clk_out[i];
                    tick[i]    <= 1'b1;
                end else begin
                    cnt[i]     <= cnt[i] + DIV_W'(1);
                    tick[i]    <= 1'b0;
                end

                // The old queued value lands in div_q while a same-cycle write queues the new one.
                if (apply[i]) begin
                    div_q[i] <= div_p[i];
                end
                if (sel[i]) begin
                    div_p[i]   <= load_div;
                    pending[i] <= 1'b1;
                end else if (apply[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: fixed vector table, hand sequences for divisor-swap corners, then random traffic against a timeline model.
module tb_clk_div_bank;
    localparam int NUM_CH      = 3;
    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 51;
    localparam int CH_W        = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] en;
    logic              load_valid;
    logic [CH_W-1:0]   load_ch;
    logic [DIV_W-1:0]  load_div;
    logic              sync;
    logic [NUM_CH-1:0] clk_out, tick, pending;

    int tests = 0;
    int fails = 0;
    int g;

    // Model: each channel knows the absolute edge number of its next toggle.
    longint            n = 0;
    longint            m_due   [NUM_CH];
    int                m_q     [NUM_CH];
    int                m_p     [NUM_CH];
    logic [NUM_CH-1:0] m_clk, m_tick, m_pend, m_fresh;

    clk_div_bank #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clock(clock), .reset(reset), .en(en), .load_valid(load_valid),
        .load_ch(load_ch), .load_div(load_div), .sync(sync),
        .clk_out(clk_out), .tick(tick), .pending(pending)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic sy;
`ifdef CLKDIV_SYNC_EN
        sy = sync;
`else
        sy = 1'b0;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                m_clk[i] = 0; m_tick[i] = 0; m_pend[i] = 0; m_fresh[i] = 1;
                m_q[i] = DEFAULT_DIV; m_p[i] = DEFAULT_DIV;
            end else begin
                if (sy || !en[i] || m_q[i] == 0) begin
                    m_clk[i] = 0; m_tick[i] = 0; m_fresh[i] = 1;
                    if (m_pend[i]) begin m_q[i] = m_p[i]; m_pend[i] = 0; end
                end else begin
                    // A fresh start toggles on the q-th edge counting this one.
                    if (m_fresh[i]) begin m_due[i] = n + m_q[i] - 1; m_fresh[i] = 0; end
                    m_tick[i] = 0;
                    if (n == m_due[i]) begin
                        m_clk[i] = ~m_clk[i]; m_tick[i] = 1;
                        if (m_pend[i]) begin m_q[i] = m_p[i]; m_pend[i] = 0; end
                        m_due[i] = n + m_q[i];
                    end
                end
                if (load_valid && load_ch == i) begin m_p[i] = int'(load_div); m_pend[i] = 1; end
            end
        end
        n++;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("cycle", 32'({clk_out, tick, pending}), 32'({m_clk, m_tick, m_pend}));
    endtask

    task automatic gap(input int ch, output int cnt);
        cnt = 0;
        do begin step(); cnt++; end while (!tick[ch] && cnt < 300);
    endtask

    task automatic do_reset();
        reset = 1; en = '0; load_valid = 0; load_ch = '0; load_div = '0; sync = 0;
        step(); step();
        reset = 0;
    endtask

    typedef struct {
        logic [NUM_CH-1:0] en;
        logic              lv;
        logic [CH_W-1:0]   lch;
        logic [DIV_W-1:0]  ldiv;
        int                cyc;
        logic [NUM_CH-1:0] clk;
        logic [NUM_CH-1:0] tk;
        logic [NUM_CH-1:0] pd;
    } vec_t;

    vec_t tv[16];

    initial begin
        // {en, load_valid, load_ch, load_div, edges, clk_out, tick, pending after those edges}
        tv[0]  = '{3'b111, 1'b0, 2'd0, 8'd0, 50, 3'b000, 3'b000, 3'b000};
        tv[1]  = '{3'b111, 1'b0, 2'd0, 8'd0,  1, 3'b111, 3'b111, 3'b000};
        tv[2]  = '{3'b111, 1'b1, 2'd1, 8'd3,  1, 3'b111, 3'b000, 3'b010};
        tv[3]  = '{3'b111, 1'b1, 2'd3, 8'd7,  1, 3'b111, 3'b000, 3'b010};
        tv[4]  = '{3'b111, 1'b0, 2'd0, 8'd0, 48, 3'b111, 3'b000, 3'b010};
        tv[5]  = '{3'b111, 1'b0, 2'd0, 8'd0,  1, 3'b000, 3'b111, 3'b000};
        tv[6]  = '{3'b111, 1'b0, 2'd0, 8'd0,  2, 3'b000, 3'b000, 3'b000};
        tv[7]  = '{3'b111, 1'b0, 2'd0, 8'd0,  1, 3'b010, 3'b010, 3'b000};
        tv[8]  = '{3'b110, 1'b1, 2'd0, 8'd4,  1, 3'b010, 3'b000, 3'b001};
        tv[9]  = '{3'b110, 1'b1, 2'd0, 8'd6,  1, 3'b010, 3'b000, 3'b001};
        tv[10] = '{3'b110, 1'b0, 2'd0, 8'd0,  1, 3'b000, 3'b010, 3'b000};
        tv[11] = '{3'b111, 1'b0, 2'd0, 8'd0,  6, 3'b001, 3'b011, 3'b000};
        tv[12] = '{3'b111, 1'b1, 2'd2, 8'd0,  1, 3'b001, 3'b000, 3'b100};
        tv[13] = '{3'b111, 1'b0, 2'd0, 8'd0, 38, 3'b111, 3'b110, 3'b000};
        tv[14] = '{3'b111, 1'b0, 2'd0, 8'd0,  1, 3'b011, 3'b000, 3'b000};
        tv[15] = '{3'b111, 1'b0, 2'd0, 8'd0, 20, 3'b001, 3'b011, 3'b000};

        do_reset();
        check("reset_state", 32'({clk_out, tick, pending}), 32'd0);
        for (int k = 0; k < 16; k++) begin
            en = tv[k].en; load_valid = tv[k].lv; load_ch = tv[k].lch; load_div = tv[k].ldiv;
            for (int c = 0; c < tv[k].cyc; c++) begin
                step();
                load_valid = 0;
            end
            check($sformatf("vec%0d", k), 32'({clk_out, tick, pending}), 32'({tv[k].clk, tv[k].tk, tv[k].pd}));
        end

        // Load mid half-period: old divisor finishes first, then 3-cycle half-periods.
        do_reset();
        en = 3'b111;
        for (int c = 0; c < 20; c++) step();
        load_valid = 1; load_ch = 2'd1; load_div = 8'd3;
        step();
        load_valid = 0;
        check("mid_load_pending", 32'(pending[1]), 32'd1);
        gap(1, g);
        check("mid_load_gap", g, 30);
        check("mid_load_applied", 32'({clk_out[1], pending[1]}), 32'b10);
        gap(1, g);
        check("mid_load_gap3a", g, 3);
        gap(1, g);
        check("mid_load_gap3b", g, 3);

        // Load on the exact terminal edge: toggle at 3, another 3 with the old value, then 5.
        do_reset();
        load_valid = 1; load_ch = 2'd1; load_div = 8'd3;
        step();
        load_valid = 0;
        step();
        check("stopped_apply", 32'(pending), 32'd0);
        en = 3'b010;
        step(); step();
        load_valid = 1; load_div = 8'd5;
        step();
        load_valid = 0;
        check("term_load", 32'({clk_out[1], tick[1], pending[1]}), 32'b111);
        gap(1, g);
        check("term_load_gap_old", g, 3);
        check("term_load_cleared", 32'(pending[1]), 32'd0);
        gap(1, g);
        check("term_load_gap_new", g, 5);
        gap(1, g);
        check("term_load_gap_new2", g, 5);

`ifdef CLKDIV_SYNC_EN
        // Realign: ch0 div 3 and ch1 div 6 both restart from the sync edge.
        do_reset();
        load_valid = 1; load_ch = 2'd0; load_div = 8'd3;
        step();
        load_ch = 2'd1; load_div = 8'd6;
        step();
        load_valid = 0;
        step();
        en = 3'b011;
        for (int c = 0; c < 4; c++) step();
        sync = 1;
        step();
        sync = 0;
        check("sync_clear", 32'(clk_out[1:0]), 32'd0);
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 3)  check("sync_ch0_rise", 32'({clk_out[0], tick[0]}), 32'b11);
            if (c == 6)  check("sync_ch1_rise", 32'({clk_out[1], tick[1]}), 32'b11);
            if (c == 12) check("sync_both_tick", 32'(tick[1:0]), 32'b11);
        end
`endif

        // Random traffic with occasional resets, disables and syncs.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NUM_CH; i++) en[i] = ($urandom_range(0, 19) != 0);
            load_valid = ($urandom_range(0, 7) == 0);
            load_ch    = CH_W'($urandom_range(0, 3));
            load_div   = ($urandom_range(0, 9) == 0) ? DIV_W'($urandom) : DIV_W'($urandom_range(0, 6));
            sync       = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
